// File: rtl/par_checking_sink_pkg.sv
// par_checking_sink_pkg: shared flit geometry, FSM states and LFSR helpers for the checking sink.
package par_checking_sink_pkg;
    localparam int HDR_SZ  = 2;
    localparam int PL_SZ   = 8;
    localparam int ADDR_SZ = 4;
    localparam int SRC_LSB = ADDR_SZ;
    localparam int CNT_W   = 20;
    localparam int FLIT_W_DEF = HDR_SZ + PL_SZ + ADDR_SZ;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_HALT} state_t;

    // A zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [7:0] lfsr_seed(input int id);
        return (8'(id + 1) == 8'd0) ? 8'd1 : 8'(id + 1);
    endfunction

    // Fibonacci form of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction
endpackage

// File: rtl/par_checking_sink_if.sv
// par_checking_sink_if: valid/busy flit link from a router local output into the sink.
interface par_checking_sink_if
    import par_checking_sink_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEF
);
    logic [FLIT_W-1:0] data;
    logic              valid;
    logic              busy;

    modport master (output data, valid, input busy);
    modport slave  (input data, valid, output busy);
endinterface

// File: rtl/par_checking_sink_fifo.sv
// par_checking_sink_fifo: synchronous FIFO with registered storage and occupancy count.
module par_checking_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_din;
    end

    assign o_dout  = r_mem[r_rp];
    assign o_count = r_cnt;
endmodule

// File: rtl/par_checking_sink.sv
// par_checking_sink: local-port flit consumer that drains at a programmable rate and
// counts packets and misrouted flits.
module par_checking_sink
    import par_checking_sink_pkg::*;
#(
    parameter int ID          = 0,
    parameter int SINK_HOSP   = 255,
    parameter int DEPTH       = 4,
    parameter int STOP_ON_ERR = 0,
    parameter int FLIT_W      = HDR_SZ + PL_SZ + ADDR_SZ
) (
    input  logic                clk,
    input  logic                reset,
    par_checking_sink_if.slave  s,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    err_count,
    output logic                err,
    output logic [ADDR_SZ-1:0]  last_src
);
    localparam int AW = $clog2(DEPTH);

    state_t             r_state;
    logic               r_busy;
    logic [7:0]         r_lfsr;
    logic [CNT_W-1:0]   r_pkt;
    logic [CNT_W-1:0]   r_errc;
    logic               r_err;
    logic [ADDR_SZ-1:0] r_src;

    logic [FLIT_W-1:0]  w_head;
    logic [AW:0]        w_cnt;
    logic [AW:0]        w_cnt_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_bad;
    logic               w_drain_ok;
    logic               w_halt_go;
    logic               w_unused;

    par_checking_sink_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (s.data),
        .o_dout  (w_head),
        .o_count (w_cnt)
    );

    assign w_push     = s.valid & ~r_busy;
    assign w_drain_ok = (SINK_HOSP == 255) || (r_lfsr < 8'(SINK_HOSP));
    assign w_pop      = (r_state == S_DRAIN) & w_drain_ok & (w_cnt != '0);
    assign w_bad      = w_head[ADDR_SZ-1:0] != ADDR_SZ'(ID);
    assign w_halt_go  = w_pop & w_bad & (STOP_ON_ERR != 0);
    assign w_cnt_nxt  = w_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_unused   = ^w_head[FLIT_W-1:SRC_LSB+ADDR_SZ];

    // busy is registered from next-cycle fullness so the link sees a clean flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b1;
            r_lfsr  <= lfsr_seed(ID);
            r_pkt   <= '0;
            r_errc  <= '0;
            r_err   <= 1'b0;
            r_src   <= '0;
        end else begin
            r_lfsr  <= lfsr_next(r_lfsr);
            r_busy  <= (w_cnt_nxt == (AW+1)'(DEPTH)) | w_halt_go | (r_state == S_HALT);
            r_state <= (r_state == S_IDLE) ? ((w_cnt_nxt != '0) ? S_DRAIN : S_IDLE) :
                       (r_state == S_DRAIN) ? (w_halt_go ? S_HALT :
                                               (w_cnt_nxt == '0) ? S_IDLE : S_DRAIN) :
                       S_HALT;
            if (w_pop) begin
                r_pkt <= r_pkt + CNT_W'(r_pkt != '1);
                r_src <= w_head[SRC_LSB +: ADDR_SZ];
            end
            if (w_pop & w_bad) begin
                r_errc <= r_errc + CNT_W'(r_errc != '1);
                r_err  <= 1'b1;
            end
        end
    end

    assign s.busy    = r_busy;
    assign pkt_count = r_pkt;
    assign err_count = r_errc;
    assign err       = r_err;
    assign last_src  = r_src;
endmodule

// File: tb/tb_par_checking_sink.sv
// tb_par_checking_sink: directed checks of three sink configurations (free drain, no drain, halt on error).
module tb_par_checking_sink;
    import par_checking_sink_pkg::*;

    localparam int FW = HDR_SZ + PL_SZ + ADDR_SZ;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [CNT_W-1:0]   pkt_a, errc_a, pkt_h, errc_h, pkt_s, errc_s;
    logic               err_a, err_h, err_s;
    logic [ADDR_SZ-1:0] src_a, src_h, src_s;

    par_checking_sink_if #(.FLIT_W(FW)) if_a ();
    par_checking_sink_if #(.FLIT_W(FW)) if_h ();
    par_checking_sink_if #(.FLIT_W(FW)) if_s ();

    par_checking_sink #(.ID(4), .SINK_HOSP(255), .DEPTH(4), .STOP_ON_ERR(0), .FLIT_W(FW)) u_a (
        .clk(clk), .reset(reset), .s(if_a.slave),
        .pkt_count(pkt_a), .err_count(errc_a), .err(err_a), .last_src(src_a));
    par_checking_sink #(.ID(4), .SINK_HOSP(0), .DEPTH(4), .STOP_ON_ERR(0), .FLIT_W(FW)) u_h (
        .clk(clk), .reset(reset), .s(if_h.slave),
        .pkt_count(pkt_h), .err_count(errc_h), .err(err_h), .last_src(src_h));
    par_checking_sink #(.ID(4), .SINK_HOSP(255), .DEPTH(4), .STOP_ON_ERR(1), .FLIT_W(FW)) u_s (
        .clk(clk), .reset(reset), .s(if_s.slave),
        .pkt_count(pkt_s), .err_count(errc_s), .err(err_s), .last_src(src_s));

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] fl(input int d, input int sr);
        return {HDR_SZ'(1), (PL_SZ-ADDR_SZ)'(10), ADDR_SZ'(sr), ADDR_SZ'(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_a.valid = 1'b0; if_a.data = '0;
        if_h.valid = 1'b0; if_h.data = '0;
        if_s.valid = 1'b0; if_s.data = '0;
        tick();
        chk("rst_busy", 32'(if_a.busy), 1);
        chk("rst_pkt", 32'(pkt_a), 0);
        chk("rst_errc", 32'(errc_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_src", 32'(src_a), 0);
        // single good flit: busy drops on first edge, push next, pop the one after
        if_a.valid = 1'b1; if_a.data = fl(4, 2);
        reset = 1'b0;
        tick();
        chk("t1_busy_low", 32'(if_a.busy), 0);
        chk("t1_no_push_yet", 32'(pkt_a), 0);
        tick();
        if_a.valid = 1'b0;
        chk("t1_latency", 32'(pkt_a), 0);
        tick();
        chk("t1_pkt", 32'(pkt_a), 1);
        chk("t1_err", 32'(err_a), 0);
        chk("t1_src", 32'(src_a), 2);
        chk("t1_errc", 32'(errc_a), 0);
        // no-drain sink: 4 accepted, busy rises on the 4th push
        if_h.valid = 1'b1; if_h.data = fl(4, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_busy_fill", 32'(if_h.busy), 32'(i == 3));
            if_h.data = fl(4, i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_busy_hold", 32'(if_h.busy), 1);
            chk("t2_pkt", 32'(pkt_h), 0);
        end
        if_h.valid = 1'b0;
        // reset clears buffered flits and counters
        reset = 1'b1;
        #1;
        chk("t6_busy_in_rst", 32'(if_h.busy), 1);
        chk("t6_a_pkt_clr", 32'(pkt_a), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_busy_rel", 32'(if_h.busy), 0);
        if_h.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_h.data = fl(4, i);
            tick();
            chk("t6_busy_3", 32'(if_h.busy), 0);
        end
        if_h.valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_busy_rst2", 32'(if_h.busy), 1);
        tick();
        reset = 1'b0;
        tick();
        if_h.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_h.data = fl(4, i);
            tick();
            chk("t6_refill", 32'(if_h.busy), 32'(i == 3));
        end
        if_h.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_a_idle_pkt", 32'(pkt_a), 0);
            chk("t6_h_pkt", 32'(pkt_h), 0);
        end
        // 100 back-to-back flits with full drain rate
        if_a.valid = 1'b1; if_a.data = fl(4, 0);
        for (int j = 0; j < 100; j++) begin
            tick();
            chk("t3_busy", 32'(if_a.busy), 0);
            chk("t3_pkt", 32'(pkt_a), 32'(j));
            if (j > 0) chk("t3_order", 32'(src_a), 32'((j - 1) % 16));
            if_a.data = fl(4, (j + 1) % 16);
        end
        if_a.valid = 1'b0;
        tick();
        chk("t3_pkt_100", 32'(pkt_a), 100);
        chk("t3_src_last", 32'(src_a), 3);
        chk("t3_errc", 32'(errc_a), 0);
        // misroute without halting
        if_a.valid = 1'b1; if_a.data = fl(3, 7);
        tick();
        if_a.valid = 1'b0;
        tick();
        chk("t4_pkt", 32'(pkt_a), 101);
        chk("t4_errc", 32'(errc_a), 1);
        chk("t4_err", 32'(err_a), 1);
        chk("t4_src", 32'(src_a), 7);
        if_a.valid = 1'b1; if_a.data = fl(4, 9);
        tick();
        if_a.valid = 1'b0;
        tick();
        chk("t4_pkt_good", 32'(pkt_a), 102);
        chk("t4_errc_keep", 32'(errc_a), 1);
        chk("t4_err_sticky", 32'(err_a), 1);
        chk("t4_src_good", 32'(src_a), 9);
        // misroute with halt
        if_s.valid = 1'b1; if_s.data = fl(3, 5);
        tick();
        if_s.valid = 1'b0;
        tick();
        chk("t5_busy_halt", 32'(if_s.busy), 1);
        chk("t5_pkt", 32'(pkt_s), 1);
        chk("t5_errc", 32'(errc_s), 1);
        chk("t5_err", 32'(err_s), 1);
        if_s.valid = 1'b1; if_s.data = fl(4, 6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_busy_stuck", 32'(if_s.busy), 1);
            chk("t5_pkt_frozen", 32'(pkt_s), 1);
        end
        if_s.valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_busy_rst", 32'(if_s.busy), 1);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_busy_rel", 32'(if_s.busy), 0);
        chk("t5_pkt_clr", 32'(pkt_s), 0);
        chk("t5_errc_clr", 32'(errc_s), 0);
        chk("t5_err_clr", 32'(err_s), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
